// File: rtl/cva6_axi_txn_monitor.sv
// +----------------------------------------------------------------------------+
// | cva6_axi_txn_monitor                                                       |
// | Passive AXI health monitor: outstanding bursts, error counts, watchdogs,   |
// | protocol-violation flag and level interrupt. Optional read stall tracking  |
// | is built when CVA6_AXI_MON_STALL_TRACK_EN is defined.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cva6_axi_txn_monitor #(
  parameter  int MAX_OUTSTANDING = 16,
  parameter  int TIMEOUT_CYCLES  = 4096,
  parameter  int ERR_CNT_W       = 16,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int TMR_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 aw_valid_i,
  input  logic                 aw_ready_i,
  input  logic                 ar_valid_i,
  input  logic                 ar_ready_i,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
  input  logic [1:0]           b_resp_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  input  logic [1:0]           r_resp_i,
  output logic [OUT_W-1:0]     wr_outstanding_o,
  output logic [OUT_W-1:0]     rd_outstanding_o,
  output logic [ERR_CNT_W-1:0] wr_err_cnt_o,
  output logic [ERR_CNT_W-1:0] rd_err_cnt_o,
  output logic                 wr_timeout_o,
  output logic                 rd_timeout_o,
  output logic                 proto_err_o,
  output logic [TMR_W-1:0]     rd_max_stall_o,
  output logic                 irq_o
);

  localparam logic [OUT_W-1:0]     OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TMR_W-1:0]     TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [1:0]           SLVERR  = 2'b10;
  localparam logic [1:0]           DECERR  = 2'b11;

  logic aw_hs, ar_hs, b_hs, r_hs, r_done;
  logic b_err, r_err;
  logic wr_proto, rd_proto;

  logic [OUT_W-1:0]     wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [TMR_W-1:0]     wr_tmr_q, wr_tmr_d, rd_tmr_q, rd_tmr_d;
  logic [ERR_CNT_W-1:0] wr_err_q, rd_err_q;
  logic                 wr_to_q, rd_to_q, proto_q;

  assign aw_hs  = aw_valid_i & aw_ready_i;
  assign ar_hs  = ar_valid_i & ar_ready_i;
  assign b_hs   = b_valid_i & b_ready_i;
  assign r_hs   = r_valid_i & r_ready_i;
  assign r_done = r_hs & r_last_i;
  assign b_err  = (b_resp_i == SLVERR) || (b_resp_i == DECERR);
  assign r_err  = (r_resp_i == SLVERR) || (r_resp_i == DECERR);

  // Returns {violation, next count}; over/underflow holds the count and flags.
  function automatic logic [OUT_W:0] next_cnt(input logic [OUT_W-1:0] cnt,
                                               input logic inc, input logic dec);
    logic             viol;
    logic [OUT_W-1:0] nxt;
    viol = 1'b0;
    nxt  = cnt;
    if (inc && !dec) begin
      if (cnt == OUT_MAX) viol = 1'b1;
      else                nxt  = cnt + OUT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) viol = 1'b1;
      else           nxt  = cnt - OUT_W'(1);
    end
    return {viol, nxt};
  endfunction

  function automatic logic [TMR_W-1:0] next_tmr(input logic [TMR_W-1:0] tmr,
                                                input logic progress,
                                                input logic [OUT_W-1:0] out_nxt);
    if (progress || (out_nxt == '0)) return '0;
    if (tmr == TMR_MAX)              return tmr;
    return tmr + TMR_W'(1);
  endfunction

  always_comb begin
    {wr_proto, wr_out_d} = next_cnt(wr_out_q, aw_hs, b_hs);
    {rd_proto, rd_out_d} = next_cnt(rd_out_q, ar_hs, r_done);
    wr_tmr_d             = next_tmr(wr_tmr_q, b_hs, wr_out_d);
    rd_tmr_d             = next_tmr(rd_tmr_q, r_hs, rd_out_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_out_q <= '0;
      rd_out_q <= '0;
      wr_tmr_q <= '0;
      rd_tmr_q <= '0;
      wr_err_q <= '0;
      rd_err_q <= '0;
      wr_to_q  <= 1'b0;
      rd_to_q  <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;
      wr_tmr_q <= wr_tmr_d;
      rd_tmr_q <= rd_tmr_d;
      // clear wins over any same-cycle error or flag event
      if (clear_i) begin
        wr_err_q <= '0;
        rd_err_q <= '0;
        wr_to_q  <= 1'b0;
        rd_to_q  <= 1'b0;
        proto_q  <= 1'b0;
      end else begin
        if (b_hs && b_err && (wr_err_q != ERR_MAX)) wr_err_q <= wr_err_q + ERR_CNT_W'(1);
        if (r_hs && r_err && (rd_err_q != ERR_MAX)) rd_err_q <= rd_err_q + ERR_CNT_W'(1);
        if (wr_tmr_q == TMR_MAX) wr_to_q <= 1'b1;
        if (rd_tmr_q == TMR_MAX) rd_to_q <= 1'b1;
        if (wr_proto || rd_proto) proto_q <= 1'b1;
      end
    end
  end

`ifdef CVA6_AXI_MON_STALL_TRACK_EN
  logic [TMR_W-1:0] rd_max_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                     rd_max_stall_q <= '0;
    else if (clear_i)                              rd_max_stall_q <= '0;
    else if (r_hs && (rd_tmr_q > rd_max_stall_q))  rd_max_stall_q <= rd_tmr_q;
  end

  assign rd_max_stall_o = rd_max_stall_q;
`else
  assign rd_max_stall_o = '0;
`endif

  assign wr_outstanding_o = wr_out_q;
  assign rd_outstanding_o = rd_out_q;
  assign wr_err_cnt_o     = wr_err_q;
  assign rd_err_cnt_o     = rd_err_q;
  assign wr_timeout_o     = wr_to_q;
  assign rd_timeout_o     = rd_to_q;
  assign proto_err_o      = proto_q;
  assign irq_o            = wr_to_q | rd_to_q | proto_q | (wr_err_q != '0) | (rd_err_q != '0);

endmodule

`default_nettype wire

// File: doc/cva6_axi_txn_monitor.md
Name: cva6_axi_txn_monitor

Overview:
- Passive, single-clock observer on the CVA6 cluster's AXI master port, on the SoC side of the CVA6-to-SoC clock-domain crossing, before the SoC crossbar.
- Tracks outstanding read and write bursts and counts SLVERR/DECERR responses.
- Detects stalled transactions (watchdog) and protocol violations.
- Raises a level interrupt for the SoC debug/health unit. Never drives or back-pressures the bus.

Parameters:
- MAX_OUTSTANDING, 16, saturation limit of each outstanding-burst counter; OUT_W = $clog2(MAX_OUTSTANDING+1).
- TIMEOUT_CYCLES, 4096, cycles without response progress, while transactions are outstanding, before a timeout flag is set; TMR_W = $clog2(TIMEOUT_CYCLES+1).
- ERR_CNT_W, 16, width of each saturating error counter.

Ports:
- clk_i  in  1  SoC-domain clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  sync clear of sticky flags and error counters
- aw_valid_i, aw_ready_i  in  1 each  AW handshake
- ar_valid_i, ar_ready_i  in  1 each  AR handshake
- b_valid_i, b_ready_i  in  1 each  B handshake
- b_resp_i  in  2  B response code
- r_valid_i, r_ready_i, r_last_i  in  1 each  R handshake, last beat
- r_resp_i  in  2  R response code
- wr_outstanding_o  out  OUT_W  writes accepted on AW, not yet answered on B
- rd_outstanding_o  out  OUT_W  reads accepted on AR, not yet completed by R last
- wr_err_cnt_o  out  ERR_CNT_W  errored B responses
- rd_err_cnt_o  out  ERR_CNT_W  errored R beats
- wr_timeout_o  out  1  sticky write-watchdog flag
- rd_timeout_o  out  1  sticky read-watchdog flag
- proto_err_o  out  1  sticky protocol-violation flag
- rd_max_stall_o  out  TMR_W  see Optional Feature
- irq_o  out  1  level interrupt

Behaviour:
- Reset: rst_i is asynchronous and active-high; clk_i is the single clock. Every output, counter and timer is 0 on reset. Reset mid-burst discards all tracking; there is no recovery of in-flight state.
- Handshake definition: X_hs = X_valid_i & X_ready_i. All outputs are registered, so each reflects the cycle's events one cycle later.
- Write counter:
  - +1 on aw_hs, -1 on b_hs; both in the same cycle leaves it unchanged.
  - Increment at MAX_OUTSTANDING: counter holds, proto_err set.
  - b_hs with counter 0 and no same-cycle aw_hs: counter stays 0, proto_err set.
- Read counter: same rules, with ar_hs as increment and (r_hs & r_last_i) as decrement.
- Write timer:
  - Cleared when b_hs occurs or when the next-state wr_outstanding is 0.
  - Otherwise +1 per cycle, saturating at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets wr_timeout_o (sticky).
- Read timer: same rules, cleared on any r_hs (any beat counts as progress), setting rd_timeout_o.
- Error counters:
  - wr_err_cnt +1 on b_hs with b_resp_i[1]=1 (2'b10 SLVERR or 2'b11 DECERR).
  - rd_err_cnt +1 per r_hs beat with r_resp_i[1]=1.
  - OKAY and EXOKAY are not counted. Both counters saturate at all-ones.
- clear_i:
  - Zeroes the error counters, the timeout/proto flags and rd_max_stall.
  - Has priority: error or flag events in the same cycle are discarded.
  - Outstanding counters and timers are not affected.
- irq_o = wr_timeout_o | rd_timeout_o | proto_err_o | (wr_err_cnt_o != 0) | (rd_err_cnt_o != 0). Combinational from registered state, so it asserts the same cycle the flag/counter output changes.

Optional Feature:
- Macro: CVA6_AXI_MON_STALL_TRACK_EN.
- Defined: on every r_hs, rd_max_stall <= max(rd_max_stall, read timer value before clear). Cleared by clear_i or reset.
- Undefined: rd_max_stall_o is tied to 0 and no stall-tracking logic is built.

Test Plan:
- TIMEOUT_CYCLES=16. 3 AW handshakes, then 3 B OKAY on consecutive cycles -> wr_outstanding_o 1,2,3 then 2,1,0; wr_err_cnt_o=0; irq_o=0 throughout.
- Same cycle aw_hs and b_hs with wr_outstanding_o=2 -> stays 2. b_hs at 0 -> stays 0, proto_err_o=1 next cycle, irq_o=1.
- TIMEOUT_CYCLES=16. 1 AR handshake, no R for 20 cycles -> rd_timeout_o=1 exactly 16 cycles after the counter becomes 1. A single R beat with r_last_i=0 at cycle 10 restarts the count.
- 4-beat read with r_resp_i OKAY, SLVERR, DECERR, EXOKAY -> rd_err_cnt_o=2. Then clear_i coincident with one SLVERR B -> wr_err_cnt_o=0, irq_o=0.
- 17 AW handshakes with MAX_OUTSTANDING=16 and no B -> wr_outstanding_o saturates at 16, proto_err_o=1. Assert rst_i mid-sequence -> all outputs 0 asynchronously.
- With CVA6_AXI_MON_STALL_TRACK_EN: R beats at timer values 5 then 3 -> rd_max_stall_o=5. Without the macro: rd_max_stall_o=0.
